// File: rtl/logic_issue_rv32i.sv
// Issue stage for the RV32I XOR/OR/AND gate unit: decode, operand select and a
// two-entry valid/ready skid buffer feeding the unit's in1/in2/type inputs.
module logic_issue_rv32i #(
    parameter logic [2:0] ILLEGAL_TYPE = 3'b011,
    parameter int         CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [31:0]      rs1_data,
    input  logic [31:0]      rs2_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      op_in1,
    output logic [31:0]      op_in2,
    output logic [2:0]       op_type,
    output logic [4:0]       op_rd,
    output logic             op_illegal,
    output logic [CNT_W-1:0] issued_cnt
);

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [2:0]  typ;
        logic [4:0]  rd;
        logic        ill;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    entry_t           m_q, s_q;
    entry_t           dec_e;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_m, load_s, m_from_s;
    logic             accept, consume;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_r, is_i, f3_ok;
    logic [2:0] f3_type;
    logic       unused_rs1_field;

    assign opcode           = instr[6:0];
    assign funct3           = instr[14:12];
    assign funct7           = instr[31:25];
    assign unused_rs1_field = ^instr[19:15];

    assign is_r = (opcode == 7'b0110011) && (funct7 == 7'b0000000);
    assign is_i = (opcode == 7'b0010011);

    always_comb begin
        f3_ok   = 1'b1;
        f3_type = ILLEGAL_TYPE;
        unique case (funct3)
            3'b100:  f3_type = 3'b000;
            3'b110:  f3_type = 3'b001;
            3'b111:  f3_type = 3'b010;
            default: f3_ok   = 1'b0;
        endcase
    end

    // Operands are captured even for illegal entries; imm only for OP-IMM.
    always_comb begin
        dec_e     = '0;
        dec_e.in1 = rs1_data;
        dec_e.in2 = is_i ? {{20{instr[31]}}, instr[31:20]} : rs2_data;
        dec_e.rd  = instr[11:7];
        if ((is_r || is_i) && f3_ok) begin
            dec_e.typ = f3_type;
            dec_e.ill = 1'b0;
        end else begin
            dec_e.typ = ILLEGAL_TYPE;
            dec_e.ill = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Output logic: handshakes depend on registered state only
    always_comb begin
        in_ready  = (state_q != FULL);
        out_valid = (state_q != EMPTY);
    end

    assign accept  = in_valid && in_ready && !flush;
    assign consume = out_valid && out_ready;

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        load_m   = 1'b0;
        load_s   = 1'b0;
        m_from_s = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = BUSY;
                        load_m  = 1'b1;
                    end
                end
                BUSY: begin
                    if (accept && consume) begin
                        load_m = 1'b1;
                    end else if (accept) begin
                        state_d = FULL;
                        load_s  = 1'b1;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        state_d  = BUSY;
                        m_from_s = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            if (load_m) begin
                m_q <= dec_e;
            end else if (m_from_s) begin
                m_q <= s_q;
            end
            if (load_s) begin
                s_q <= dec_e;
            end
        end
    end

    // A consume in a flush cycle still counts
    always_comb begin
        cnt_d = cnt_q;
        if (consume) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign op_in1     = m_q.in1;
    assign op_in2     = m_q.in2;
    assign op_type    = m_q.typ;
    assign op_rd      = m_q.rd;
    assign op_illegal = m_q.ill;
    assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_logic_issue_rv32i.sv
// Bench for logic_issue_rv32i: queue-based reference model checked every cycle,
// plus directed literal cases for decode, back-pressure, flush, reset and wrap.
module tb_logic_issue_rv32i;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready;
    logic [31:0] instr, rs1_data, rs2_data;
    logic        out_valid, out_ready;
    logic [31:0] op_in1, op_in2;
    logic [2:0]  op_type;
    logic [4:0]  op_rd;
    logic        op_illegal;
    logic [15:0] issued_cnt;

    always #5 clk = ~clk;

    logic_issue_rv32i #(.ILLEGAL_TYPE(3'b011), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_in1(op_in1), .op_in2(op_in2), .op_type(op_type),
        .op_rd(op_rd), .op_illegal(op_illegal), .issued_cnt(issued_cnt)
    );

    typedef struct {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [2:0]  t;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    int   mcnt = 0;
    bit   chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the instruction-set tables
    function automatic exp_t model_dec(input logic [31:0] ins, input logic [31:0] r1,
                                       input logic [31:0] r2);
        exp_t e;
        int   f3;
        bit   kind_ok;
        f3      = int'(ins[14:12]);
        kind_ok = (ins[6:0] == 7'h33 && ins[31:25] == 7'h00) || (ins[6:0] == 7'h13);
        e.in1   = r1;
        e.rd    = ins[11:7];
        e.in2   = (ins[6:0] == 7'h13) ? {{20{ins[31]}}, ins[31:20]} : r2;
        if (kind_ok && f3 == 4) begin e.t = 3'd0; e.ill = 0; end
        else if (kind_ok && f3 == 6) begin e.t = 3'd1; e.ill = 0; end
        else if (kind_ok && f3 == 7) begin e.t = 3'd2; e.ill = 0; end
        else begin e.t = 3'd3; e.ill = 1; end
        return e;
    endfunction

    // Model update on each edge, from the values the DUT sees
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            mcnt = 0;
        end else begin
            automatic bit rdy = (q.size() < 2);
            if (q.size() > 0 && out_ready) begin
                void'(q.pop_front());
                mcnt = (mcnt + 1) % 65536;
            end
            if (flush) q.delete();
            else if (in_valid && rdy) q.push_back(model_dec(instr, rs1_data, rs2_data));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", out_valid, q.size() > 0);
            chk("in_ready", in_ready, q.size() < 2);
            chk("issued_cnt", issued_cnt, mcnt);
            if (q.size() > 0) begin
                chk("op_in1", op_in1, q[0].in1);
                chk("op_type", op_type, q[0].t);
                chk("op_rd", op_rd, q[0].rd);
                chk("op_illegal", op_illegal, q[0].ill);
                if (!q[0].ill) chk("op_in2", op_in2, q[0].in2);
            end
        end
    end

    task automatic cyc(input bit iv, input logic [31:0] ins, input logic [31:0] r1,
                       input logic [31:0] r2, input bit ordy, input bit fl);
        in_valid  = iv;
        instr     = ins;
        rs1_data  = r1;
        rs2_data  = r2;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        rst = 0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [2:0]  f3s [3] = '{3'b100, 3'b110, 3'b111};
        w = $urandom;
        case ($urandom_range(0, 3))
            0: w = {7'h00, w[24:15], f3s[$urandom_range(0, 2)], w[11:7], 7'h33};
            1: w = {w[31:15], f3s[$urandom_range(0, 2)], w[11:7], 7'h13};
            2: w = {w[31:7], ($urandom_range(0, 1) != 0) ? 7'h33 : 7'h13};
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        rst = 1; flush = 0; in_valid = 0; out_ready = 0;
        instr = 0; rs1_data = 0; rs2_data = 0;
        do_reset();
        chk_en = 1;

        chk("rst out_valid", out_valid, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst op_in1", op_in1, 0);
        chk("rst op_type", op_type, 0);
        chk("rst issued_cnt", issued_cnt, 0);

        // Directed decode cases, one per cycle at full throughput
        cyc(1, 32'h0020C1B3, 32'hF0F0F0F0, 32'h0FF00FF0, 1, 0);
        chk("xor valid", out_valid, 1);
        chk("xor type", op_type, 3'b000);
        chk("xor in2", op_in2, 32'h0FF00FF0);
        chk("xor rd", op_rd, 5'd3);
        chk("xor illegal", op_illegal, 0);
        cyc(1, 32'hFFF37293, 32'h11111111, 32'h22222222, 1, 0);
        chk("andi type", op_type, 3'b010);
        chk("andi in2", op_in2, 32'hFFFFFFFF);
        cyc(1, 32'h7FF06093, 32'h33333333, 32'h44444444, 1, 0);
        chk("ori type", op_type, 3'b001);
        chk("ori in2", op_in2, 32'h000007FF);
        cyc(1, 32'h002081B3, 32'h1, 32'h2, 1, 0);
        chk("add illegal", op_illegal, 1);
        chk("add type", op_type, 3'b011);
        cyc(1, 32'h4020C1B3, 32'h1, 32'h2, 1, 0);
        chk("sub-xor illegal", op_illegal, 1);
        chk("sub-xor type", op_type, 3'b011);
        cyc(0, 0, 0, 0, 1, 0);

        // Back-pressure: A,B fill the buffer, C waits, then drain in order
        do_reset();
        cyc(1, 32'h0020C1B3, 32'hAAAA0001, 0, 0, 0);
        cyc(1, 32'h0020E1B3, 32'hBBBB0002, 0, 0, 0);
        chk("full in_ready", in_ready, 0);
        cyc(1, 32'h0020F1B3, 32'hCCCC0003, 0, 0, 0);
        chk("full holds A", op_in1, 32'hAAAA0001);
        cyc(1, 32'h0020F1B3, 32'hCCCC0003, 0, 1, 0);
        chk("drain B", op_in1, 32'hBBBB0002);
        cyc(1, 32'h0020F1B3, 32'hCCCC0003, 0, 1, 0);
        chk("drain C", op_in1, 32'hCCCC0003);
        cyc(0, 0, 0, 0, 1, 0);
        chk("drain empty", out_valid, 0);
        chk("drain cnt", issued_cnt, 16'd3);

        // Flush while full, with a competing input
        cyc(1, 32'h0020C1B3, 32'h1, 0, 0, 0);
        cyc(1, 32'h0020C1B3, 32'h2, 0, 0, 0);
        cyc(1, 32'h0020C1B3, 32'h3, 0, 0, 1);
        chk("flush out_valid", out_valid, 0);
        chk("flush in_ready", in_ready, 1);
        cyc(0, 0, 0, 0, 1, 0);
        chk("flush no capture", out_valid, 0);

        // Reset while full
        cyc(1, 32'h0020C1B3, 32'h5, 32'h6, 0, 0);
        cyc(1, 32'h0020C1B3, 32'h7, 32'h8, 0, 0);
        rst = 1;
        cyc(1, 32'h0020C1B3, 32'h9, 32'hA, 0, 1);
        rst = 0;
        chk("rst2 out_valid", out_valid, 0);
        chk("rst2 in_ready", in_ready, 1);
        chk("rst2 in1", op_in1, 0);
        chk("rst2 in2", op_in2, 0);
        chk("rst2 rd", op_rd, 0);
        chk("rst2 cnt", issued_cnt, 0);
        cyc(0, 0, 0, 0, 1, 0);
        chk("rst2 held", out_valid, 0);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 499) == 0);
            cyc($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom,
                $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
        end
        rst = 0;

        // Counter wrap
        do_reset();
        for (int i = 0; i < 70000 && mcnt != 65535; i++) begin
            cyc(1, rand_instr(), $urandom, $urandom, 1, 0);
        end
        chk("cnt at max", issued_cnt, 16'hFFFF);
        cyc(0, 0, 0, 0, 1, 0);
        chk("cnt wrap", issued_cnt, 16'h0000);
        cyc(0, 0, 0, 0, 1, 0);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
